fp_alu_sched: RTL and testbench

- Two-requester scheduler that shares one single-precision FP datapath: one SubOp instance and one MultiOp instance.
- Each requester issues operations over a valid/ready handshake. The block arbitrates round-robin, latches operands, runs the shared combinational units for one cycle, and registers the result.
- The registered result is returned on a single response channel, tagged with the requester ID, and the channel supports backpressure.
- The block sits between the ALU front-end ports and the arithmetic units.

---
 rtl/fp_alu_pkg.sv | 33 +++
 rtl/MultiOp.sv | 51 +++++
 rtl/SubOp.sv | 87 ++++++++
 rtl/fp_alu_sched_rr_arb2.sv | 45 ++++
 rtl/fp_alu_sched.sv | 159 +++++++++++++++
 tb/tb_fp_alu_sched.sv | 290 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fp_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_alu_pkg
// Purpose  : Shared constants for the two-requester FP ALU scheduler:
//            opcodes, FSM state encoding and IEEE-754 single constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fp_alu_pkg;

    // Opcodes presented on reqN_op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    // Scheduler FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // IEEE-754 single-precision constants
    localparam int          FP_SIGN_BIT  = 31;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

    // Flip the sign of a single-precision value. Addition is performed on
    // the subtract unit as A - (-B).
    function automatic logic [31:0] fp_negate(input logic [31:0] x);
        return {~x[FP_SIGN_BIT], x[FP_SIGN_BIT-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/MultiOp.sv
`default_nettype none
// ============================================================================
// Module   : MultiOp
// Purpose  : Combinational single-precision multiply, result = para1*para2.
//            Subnormal inputs are flushed to zero, the result is truncated
//            toward zero, and Inf/NaN inputs are not special-cased.
// Ports    : para1, para2    - IEEE-754 single operands
//            result          - product
//            under_overflow  - exponent left the normal range
// Revision : 1.0 - initial release
// ============================================================================
module MultiOp (
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic [31:0] result,
    output logic        under_overflow
);

    logic              w_sign;
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [47:0]       w_prod;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp;

    always_comb begin
        w_sign = para1[31] ^ para2[31];
        w_ea   = para1[30:23];
        w_eb   = para2[30:23];
        w_prod = {1'b1, para1[22:0]} * {1'b1, para2[22:0]};

        // Product of two [1,2) mantissas lies in [1,4); bit 47 marks >= 2
        w_exp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127
              + (w_prod[47] ? 10'sd1 : 10'sd0);
        w_frac = w_prod[47] ? 23'(w_prod >> 24) : 23'(w_prod >> 23);

        result         = {w_sign, w_exp[7:0], w_frac};
        under_overflow = 1'b0;
        if (w_ea == 8'd0 || w_eb == 8'd0) begin
            result = {w_sign, 31'd0};
        end else if (w_exp >= 10'sd255) begin
            result         = {w_sign, 8'hFF, 23'd0};
            under_overflow = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            result         = {w_sign, 31'd0};
            under_overflow = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/SubOp.sv
`default_nettype none
// ============================================================================
// Module   : SubOp
// Purpose  : Combinational single-precision subtract, result = para1 - para2.
//            Subnormal inputs are flushed to zero, the result is truncated
//            toward zero, and Inf/NaN inputs are not special-cased.
// Ports    : para1, para2    - IEEE-754 single operands
//            result          - para1 - para2
//            under_overflow  - exponent left the normal range
// Revision : 1.0 - initial release
// ============================================================================
module SubOp (
    input  logic [31:0] para1,
    input  logic [31:0] para2,
    output logic [31:0] result,
    output logic        under_overflow
);

    logic              w_sa;
    logic              w_sb;
    logic [7:0]        w_ea;
    logic [7:0]        w_eb;
    logic [23:0]       w_ma;
    logic [23:0]       w_mb;
    logic              w_swap;
    logic              w_sign;
    logic [7:0]        w_e_big;
    logic [7:0]        w_diff;
    logic [47:0]       w_m_big;
    logic [47:0]       w_m_small;
    logic [47:0]       w_m_shift;
    logic [48:0]       w_sum;
    logic [5:0]        w_lz;
    logic [22:0]       w_frac;
    logic signed [9:0] w_exp;

    always_comb begin
        w_sa = para1[31];
        // Subtraction: the second operand enters with its sign inverted
        w_sb = ~para2[31];
        w_ea = para1[30:23];
        w_eb = para2[30:23];
        w_ma = (w_ea == 8'd0) ? 24'd0 : {1'b1, para1[22:0]};
        w_mb = (w_eb == 8'd0) ? 24'd0 : {1'b1, para2[22:0]};

        // Larger magnitude goes first so the difference never goes negative
        w_swap    = {w_ea, w_ma} < {w_eb, w_mb};
        w_sign    = w_swap ? w_sb : w_sa;
        w_e_big   = w_swap ? w_eb : w_ea;
        w_diff    = w_swap ? (w_eb - w_ea) : (w_ea - w_eb);
        w_m_big   = w_swap ? {w_mb, 24'd0} : {w_ma, 24'd0};
        w_m_small = w_swap ? {w_ma, 24'd0} : {w_mb, 24'd0};
        w_m_shift = (w_diff > 8'd47) ? 48'd0 : (w_m_small >> w_diff);

        if (w_sa ^ w_sb) begin
            w_sum = {1'b0, w_m_big} - {1'b0, w_m_shift};
        end else begin
            w_sum = {1'b0, w_m_big} + {1'b0, w_m_shift};
        end

        // Distance of the leading one from bit 48; the last hit is the MSB
        w_lz = 6'd0;
        for (int i = 0; i <= 48; i++) begin
            if (w_sum[i]) begin
                w_lz = 6'(48 - i);
            end
        end

        // Bit 48 set means carry out, so the exponent is e_big + 1 - lz
        w_exp  = $signed({2'b00, w_e_big}) + 10'sd1 - $signed({4'b0000, w_lz});
        w_frac = 23'((w_sum << w_lz) >> 25);

        result         = {w_sign, w_exp[7:0], w_frac};
        under_overflow = 1'b0;
        if (w_sum == 49'd0) begin
            result = 32'd0;
        end else if (w_exp >= 10'sd255) begin
            result         = {w_sign, 8'hFF, 23'd0};
            under_overflow = 1'b1;
        end else if (w_exp <= 10'sd0) begin
            result         = {w_sign, 31'd0};
            under_overflow = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_alu_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant. With both requesters valid the one
//            that did not win last time is granted; the last-grant register
//            only moves when the grant is actually accepted.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_valid[1:0]    - request valids, bit N = requester N
//            i_accept        - current grant is taken this cycle
//            o_grant_valid   - at least one requester is valid
//            o_grant_id      - granted requester
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter logic RESET_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    logic r_last;

    always_comb begin
        o_grant_valid = |i_valid;
        if (&i_valid) begin
            o_grant_id = ~r_last;
        end else begin
            o_grant_id = i_valid[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= RESET_LAST;
        end else if (i_accept) begin
            r_last <= o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_alu_sched
// Purpose  : Shares one SubOp and one MultiOp between two requesters.
//            IDLE arbitrates and latches operands, EXEC runs the units for
//            one cycle and registers the result, HOLD presents it on the
//            response channel until the consumer takes it.
// Ports    : clk, rst                      - clock, sync active-high reset
//            reqN_valid/ready              - request handshake, N = 0,1
//            reqN_op/a/b                   - opcode and IEEE-754 operands
//            rsp_valid/ready               - response handshake
//            rsp_id, rsp_data, rsp_flag    - requester, result, under/overflow
//            busy                          - FSM not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module fp_alu_sched #(
    parameter logic [31:0] NAN_VALUE     = 32'h7FC00000,
    parameter logic        RR_RESET_LAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_flag,
    output logic        busy
);
    import fp_alu_pkg::*;

    logic [1:0]  r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_data;
    logic        r_rsp_flag;

    logic        w_grant_valid;
    logic        w_grant_id;
    logic        w_accept;
    logic [31:0] w_sub_b;
    logic [31:0] w_sub_res;
    logic        w_sub_uo;
    logic [31:0] w_mul_res;
    logic        w_mul_uo;
    logic [31:0] w_exec_data;
    logic        w_exec_flag;

    // Ready is masked during reset so nothing is accepted on a reset edge
    assign w_accept   = (r_state == S_IDLE) && !rst && w_grant_valid;
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_flag  = r_rsp_flag;
    assign busy      = (r_state != S_IDLE);

    rr_arb2 #(
        .RESET_LAST    (RR_RESET_LAST)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_valid       ({req1_valid, req0_valid}),
        .i_accept      (w_accept),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Add is computed as A - (-B) on the single subtract unit
    assign w_sub_b = (r_op == OP_ADD) ? fp_negate(r_b) : r_b;

    SubOp u_sub (
        .para1          (r_a),
        .para2          (w_sub_b),
        .result         (w_sub_res),
        .under_overflow (w_sub_uo)
    );

    MultiOp u_mul (
        .para1          (r_a),
        .para2          (r_b),
        .result         (w_mul_res),
        .under_overflow (w_mul_uo)
    );

    always_comb begin
        w_exec_data = w_sub_res;
        w_exec_flag = w_sub_uo;
        case (r_op)
            OP_MUL: begin
                w_exec_data = w_mul_res;
                w_exec_flag = w_mul_uo;
            end
            OP_RSV: begin
                w_exec_data = NAN_VALUE;
                w_exec_flag = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 2'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_flag  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_grant_id ? req1_op : req0_op;
                        r_a     <= w_grant_id ? req1_a  : req0_a;
                        r_b     <= w_grant_id ? req1_b  : req0_b;
                        r_id    <= w_grant_id;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_exec_data;
                    r_rsp_flag  <= w_exec_flag;
                    r_rsp_id    <= r_id;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    // Response fields keep their stale values once released
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_alu_sched
// Purpose  : Directed self-checking bench for fp_alu_sched.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_alu_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_alu_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flag   (rsp_flag),
        .busy       (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Present a request and hold it until accepted; returns at the negedge
    // of the EXEC cycle with valid dropped.
    task automatic issue(input logic id, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL issue_timeout id=%0d ready never rose", id);
        end
        @(posedge clk);
        @(negedge clk);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Counts negedges from the accept edge until rsp_valid is seen
    task automatic wait_rsp(output int lat);
        lat = 1;
        #1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL rsp_timeout rsp_valid never rose");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 32'd0; req1_b = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if ({rsp_id, rsp_flag} !== 2'b00) begin errors++; $display("FAIL reset_id_flag got %b want 00", {rsp_id, rsp_flag}); end
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sub();
        int lat;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h40400000; req0_b = 32'h3F800000;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL sub_ready got %b want 1", req0_ready); end
        @(posedge clk);
        @(negedge clk); #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL sub_ready_exec got %b want 0", req0_ready); end
        req0_valid = 1'b0;
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL sub_latency got %0d want 2", lat); end
        checks++; if (rsp_data !== 32'h40000000) begin errors++; $display("FAIL sub_data got %h want 40000000", rsp_data); end
        checks++; if ({rsp_id, rsp_flag} !== 2'b00) begin errors++; $display("FAIL sub_id_flag got %b want 00", {rsp_id, rsp_flag}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sub_busy got %b want 1", busy); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL sub_release got %b want 00", {rsp_valid, busy}); end
    endtask

    task automatic test_add_mul();
        int lat;
        issue(1'b1, 2'b00, 32'h3F800000, 32'h40000000);
        wait_rsp(lat);
        checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL add_data got %h want 40400000", rsp_data); end
        checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL add_id got %b want 1", rsp_id); end
        @(negedge clk);
        issue(1'b1, 2'b10, 32'h40000000, 32'h40400000);
        wait_rsp(lat);
        checks++; if (rsp_data !== 32'h40C00000) begin errors++; $display("FAIL mul_data got %h want 40C00000", rsp_data); end
        checks++; if ({rsp_id, rsp_flag} !== 2'b10) begin errors++; $display("FAIL mul_id_flag got %b want 10", {rsp_id, rsp_flag}); end
        @(negedge clk);
        issue(1'b0, 2'b01, 32'h3F800000, 32'h40400000);
        wait_rsp(lat);
        checks++; if (rsp_data !== 32'hC0000000) begin errors++; $display("FAIL neg_sub_data got %h want C0000000", rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic        order [8];
        int          gcyc  [8];
        logic        rids  [8];
        logic [31:0] rdat  [8];
        int ng = 0, nrsp = 0, n0 = 0, n1 = 0;
        logic exp_id;
        do_reset();
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h40400000; req0_b = 32'h3F800000;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h40000000; req1_b = 32'h40400000;
        for (int c = 0; c < 60 && nrsp < 8; c++) begin
            #1;
            checks++;
            if (req0_ready && req1_ready) begin errors++; $display("FAIL rr_both_ready cycle %0d", c); end
            if (req0_ready) begin
                if (ng < 8) begin order[ng] = 1'b0; gcyc[ng] = c; end
                ng++; n0++;
            end else if (req1_ready) begin
                if (ng < 8) begin order[ng] = 1'b1; gcyc[ng] = c; end
                ng++; n1++;
            end
            if (rsp_valid) begin
                if (nrsp < 8) begin rids[nrsp] = rsp_id; rdat[nrsp] = rsp_data; end
                nrsp++;
            end
            @(negedge clk);
            if (n0 >= 4) req0_valid = 1'b0;
            if (n1 >= 4) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (ng != 8 || nrsp != 8) begin errors++; $display("FAIL rr_counts grants %0d rsps %0d want 8 8", ng, nrsp); end
        if (ng == 8 && nrsp == 8) begin
            for (int i = 0; i < 8; i++) begin
                exp_id = i[0];
                checks++; if (order[i] !== exp_id) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", i, order[i], exp_id); end
                checks++; if (rids[i] !== exp_id) begin errors++; $display("FAIL rr_rsp_id[%0d] got %b want %b", i, rids[i], exp_id); end
                checks++; if (rdat[i] !== (exp_id ? 32'h40C00000 : 32'h40000000)) begin
                    errors++; $display("FAIL rr_rsp_data[%0d] got %h want %h", i, rdat[i], exp_id ? 32'h40C00000 : 32'h40000000);
                end
                if (i > 0) begin
                    checks++; if (gcyc[i] - gcyc[i-1] != 3) begin errors++; $display("FAIL rr_interval[%0d] got %0d want 3", i, gcyc[i] - gcyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_flags();
        int lat;
        issue(1'b0, 2'b10, 32'h7F7FFFFF, 32'h7F7FFFFF);
        wait_rsp(lat);
        checks++; if (rsp_flag !== 1'b1) begin errors++; $display("FAIL mul_ovf_flag got %b want 1", rsp_flag); end
        @(negedge clk);
        issue(1'b1, 2'b11, 32'h3F800000, 32'h3F800000);
        wait_rsp(lat);
        checks++; if (rsp_data !== 32'h7FC00000) begin errors++; $display("FAIL rsv_data got %h want 7FC00000", rsp_data); end
        checks++; if ({rsp_id, rsp_flag} !== 2'b11) begin errors++; $display("FAIL rsv_id_flag got %b want 11", {rsp_id, rsp_flag}); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 32'h3F800000, 32'h3F800000);
        wait_rsp(lat);
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h40000000; req1_b = 32'h40400000;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h40000000 || rsp_id !== 1'b0 || rsp_flag !== 1'b0) begin
                errors++; $display("FAIL bp_stable[%0d] got v%b d%h i%b f%b want v1 d40000000 i0 f0", k, rsp_valid, rsp_data, rsp_id, rsp_flag);
            end
            checks++;
            if ({req0_ready, req1_ready, busy} !== 3'b001) begin
                errors++; $display("FAIL bp_ready_busy[%0d] got %b want 001", k, {req0_ready, req1_ready, busy});
            end
            @(negedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++; if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
            errors++; $display("FAIL bp_release got %b want 001", {busy, rsp_valid, req1_ready});
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(lat);
        checks++; if (rsp_id !== 1'b1 || rsp_data !== 32'h40C00000) begin
            errors++; $display("FAIL bp_pending got id%b d%h want id1 d40C00000", rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        rsp_ready = 1'b1;
        issue(1'b0, 2'b01, 32'h40400000, 32'h3F800000);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_exec got %b want 00", {rsp_valid, busy}); end
        rst = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 2'b01, 32'h40400000, 32'h3F800000);
        wait_rsp(lat);
        rst = 1'b1;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy, rsp_id, rsp_flag} !== 4'b0000) begin
            errors++; $display("FAIL rst_hold got %b want 0000", {rsp_valid, busy, rsp_id, rsp_flag});
        end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL rst_hold_data got %h want 0", rsp_data); end
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h40400000; req1_b = 32'h3F800000;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_first_grant got %b want 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat);
        checks++; if (rsp_id !== 1'b0 || rsp_data !== 32'h40C00000) begin
            errors++; $display("FAIL rst_after_rsp got id%b d%h want id0 d40C00000", rsp_id, rsp_data);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_add_mul();
        test_round_robin();
        test_flags();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
